// File: rtl/seq_gen.sv
// seq_gen: serializes a latched pattern MSB-first as next/data strobes with pulse/gap pacing.
// Optional SEQ_GEN_REPEAT_EN macro enables continuous repeat until stop.
module seq_gen #(
   parameter int WIDTH        = 12,
   parameter int PULSE_CYCLES = 2,
   parameter int GAP_CYCLES   = 25
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [WIDTH-1:0]           pattern,
   input  logic [$clog2(WIDTH+1)-1:0] len,
   input  logic                       stop,
   output logic                       next,
   output logic                       data,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(WIDTH+1)-1:0] bits_sent
);

   localparam int LW = $clog2(WIDTH+1);
   localparam int CW = $clog2(PULSE_CYCLES+GAP_CYCLES+1);
   localparam logic [LW-1:0] WMAX  = LW'(WIDTH);
   localparam logic [LW-1:0] ONE   = LW'(1);
   localparam logic [CW-1:0] PLAST = CW'(PULSE_CYCLES-1);
   localparam logic [CW-1:0] GLAST = CW'(GAP_CYCLES-1);

   typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;

   state_t          state;
   logic [WIDTH-1:0] pat;
   logic [LW-1:0]   n_bits;
   logic [LW-1:0]   idx;
   logic [CW-1:0]   cnt;
   logic            stop_seen;
   logic            stop_now;
   logic [LW-1:0]   len_c;

   assign len_c    = (len > WMAX) ? WMAX : len;
   assign stop_now = stop_seen | stop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         pat       <= '0;
         n_bits    <= '0;
         idx       <= '0;
         cnt       <= '0;
         stop_seen <= 1'b0;
         next      <= 1'b0;
         data      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         bits_sent <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               stop_seen <= 1'b0;
               cnt       <= '0;
               if (start) begin
                  pat       <= pattern;
                  n_bits    <= len_c;
                  idx       <= len_c - ONE;
                  bits_sent <= '0;
                  if (len_c == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= PULSE;
                     next  <= 1'b1;
                     data  <= pattern[len_c - ONE];
                     busy  <= 1'b1;
                  end
               end
            end
            PULSE: begin
               if (stop) stop_seen <= 1'b1;
               if (cnt == PLAST) begin
                  cnt   <= '0;
                  next  <= 1'b0;
                  data  <= 1'b0;
                  state <= GAP;
                  if (bits_sent != n_bits) bits_sent <= bits_sent + ONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            GAP: begin
               if (stop) stop_seen <= 1'b1;
               if (cnt == GLAST) begin
                  cnt <= '0;
                  if (stop_now) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else if (idx == '0) begin
`ifdef SEQ_GEN_REPEAT_EN
                     // wrap into a new pass; done marks the pass boundary
                     idx       <= n_bits - ONE;
                     bits_sent <= '0;
                     done      <= 1'b1;
                     next      <= 1'b1;
                     data      <= pat[n_bits - ONE];
                     state     <= PULSE;
`else
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
`endif
                  end else begin
                     idx   <= idx - ONE;
                     next  <= 1'b1;
                     data  <= pat[idx - ONE];
                     state <= PULSE;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: directed checks of strobe timing, edge lengths, busy protection, stop and reset.
// Repeat-mode checks are built when SEQ_GEN_REPEAT_EN is defined.
module tb_seq_gen;

   localparam int PER = 27;
   localparam int PC  = 2;

   logic        clk;
   logic        reset;
   logic        start;
   logic [11:0] pattern;
   logic [3:0]  len;
   logic        stop;
   logic        next;
   logic        data;
   logic        busy;
   logic        done;
   logic [3:0]  bits_sent;

   int n_cmp = 0;
   int n_err = 0;
   int ns, dc, bad, nd;
   logic [15:0] bits;
   logic pn;

   seq_gen dut (
      .clk(clk), .reset(reset), .start(start), .pattern(pattern),
      .len(len), .stop(stop), .next(next), .data(data),
      .busy(busy), .done(done), .bits_sent(bits_sent)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_start(input logic [11:0] p, input logic [3:0] l);
      @(negedge clk);
      pattern = p;
      len     = l;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   // cycle 1 is the first cycle after the accepting edge
   task automatic capture(input int budget, input int inj_a, input int inj_b,
                          input int stop_at, output int o_ns,
                          output logic [15:0] o_bits, output int o_dc,
                          output int o_bad);
      logic p_next;
      int   width, last_rise;
      o_ns = 0; o_bits = '0; o_dc = -1; o_bad = 0;
      p_next = 1'b0; width = 0; last_rise = 0;
      for (int c = 1; c <= budget; c++) begin
         if (c > 1) @(negedge clk);
         start = (c == inj_a || c == inj_b);
         if (start) begin
            pattern = 12'hFFF;
            len     = 4'd12;
         end
         stop = (c == stop_at);
         if (next) begin
            if (!p_next) begin
               if (o_ns > 0 && c - last_rise != PER) o_bad++;
               o_ns++;
               o_bits = {o_bits[14:0], data};
               last_rise = c;
               width = 0;
            end else if (data != o_bits[0]) begin
               o_bad++;
            end
            width++;
         end else begin
            if (p_next && width != PC) o_bad++;
            if (data) o_bad++;
         end
         if (done) begin
            if (busy) o_bad++;
            o_dc = c;
            break;
         end else if (!busy) begin
            o_bad++;
         end
         p_next = next;
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0;
      pattern = '0; len = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_next", next, 0);
      check("rst_data", data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_bits_sent", bits_sent, 0);
      reset = 1'b0;

`ifdef SEQ_GEN_REPEAT_EN
      do_start(12'h005, 4'd3);
      bits = '0; ns = 0; nd = 0; bad = 0; pn = 1'b0; dc = -1;
      for (int c = 1; c <= 260; c++) begin
         if (c > 1) @(negedge clk);
         stop = (c == 170);
         if (next && !pn) begin
            ns++;
            if (ns <= 6) bits = {bits[14:0], data};
         end
         if (done) begin
            if (c < 170) begin
               nd++;
               if (c != 1 + nd * 81) bad++;
               if (!busy) bad++;
            end else begin
               if (busy) bad++;
               dc = c;
               break;
            end
         end else if (c < 170 && !busy) begin
            bad++;
         end
         pn = next;
      end
      stop = 1'b0;
      check("rep_bits", int'(bits), 16'h2D);
      check("rep_done_pulses", nd, 2);
      check("rep_strobes", ns, 7);
      check("rep_stop_done", dc, 190);
      check("rep_timing", bad, 0);
`else
      // basic pass
      do_start(12'h2D2, 4'd11);
      capture(400, 0, 0, 0, ns, bits, dc, bad);
      check("basic_strobes", ns, 11);
      check("basic_bits", int'(bits), 16'h02D2);
      check("basic_done_cyc", dc, 298);
      check("basic_timing", bad, 0);
      check("basic_bits_sent", bits_sent, 11);
      @(negedge clk);
      check("basic_done_1cyc", done, 0);

      // len = 0
      do_start(12'hFFF, 4'd0);
      capture(10, 0, 0, 0, ns, bits, dc, bad);
      check("len0_strobes", ns, 0);
      check("len0_done_cyc", dc, 1);
      check("len0_timing", bad, 0);

      // len clamped to WIDTH
      do_start(12'hA5C, 4'd15);
      capture(400, 0, 0, 0, ns, bits, dc, bad);
      check("len15_strobes", ns, 12);
      check("len15_bits", int'(bits), 16'h0A5C);
      check("len15_done_cyc", dc, 325);
      check("len15_timing", bad, 0);
      check("len15_bits_sent", bits_sent, 12);

      // start while busy and in the done cycle
      do_start(12'h2D2, 4'd11);
      capture(400, 55, 298, 0, ns, bits, dc, bad);
      check("busy_strobes", ns, 11);
      check("busy_bits", int'(bits), 16'h02D2);
      check("busy_done_cyc", dc, 298);
      check("busy_timing", bad, 0);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("busy_after_busy", busy, 0);
      check("busy_after_next", next, 0);

      // stop during bit 4 pulse
      do_start(12'h0A5, 4'd8);
      capture(400, 0, 0, 82, ns, bits, dc, bad);
      stop = 1'b0;
      check("stop_strobes", ns, 4);
      check("stop_bits", int'(bits), 16'h000A);
      check("stop_done_cyc", dc, 109);
      check("stop_timing", bad, 0);
      check("stop_bits_sent", bits_sent, 4);
      repeat (40) @(negedge clk);
      check("stop_no_more", next, 0);

      // async reset in second cycle of strobe 2
      do_start(12'hC00, 4'd12);
      repeat (28) @(negedge clk);
      check("ar_pre_next", next, 1);
      check("ar_pre_data", data, 1);
      check("ar_pre_busy", busy, 1);
      check("ar_pre_bits_sent", bits_sent, 1);
      #2 reset = 1'b1;
      #1;
      check("ar_next", next, 0);
      check("ar_data", data, 0);
      check("ar_busy", busy, 0);
      check("ar_bits_sent", bits_sent, 0);
      @(negedge clk);
      reset = 1'b0;
      do_start(12'h2D2, 4'd11);
      capture(400, 0, 0, 0, ns, bits, dc, bad);
      check("ar_re_strobes", ns, 11);
      check("ar_re_bits", int'(bits), 16'h02D2);
      check("ar_re_done_cyc", dc, 298);
      check("ar_re_timing", bad, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial pattern generator that drives the sequence-detector interface (`next` strobe plus one data bit per step) from a parallel pattern, paced like the bench stimulus for `seq_top`. It sits in front of the detector in the practice top level, replacing hand-written bench stimulus and push-button entry so the detector can be exercised on hardware at a fixed cadence. It is a serializer with a start/busy/done handshake, per-bit pulse and gap timing, and an optional continuous-repeat mode.

## Interface
- `WIDTH`, default 12: pattern register width, in bits.
- `PULSE_CYCLES`, default 2: number of cycles `next` is held high per bit (≥1).
- `GAP_CYCLES`, default 25: number of low cycles after each pulse (≥1).
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state and outputs immediately.
- `start`  in  1: request a transfer; sampled only in IDLE.
- `pattern`  in  WIDTH: bits to send; latched when `start` is accepted.
- `len`  in  $clog2(WIDTH+1): number of bits to send; latched with `pattern`.
- `stop`  in  1: abort request; takes effect at the end of the current bit.
- `next`  out  1: step strobe to the detector.
- `data`  out  1: bit value for the detector (its `in` input).
- `busy`  out  1: transfer in progress.
- `done`  out  1: single-cycle completion pulse.
- `bits_sent`  out  $clog2(WIDTH+1): count of bits whose pulse has completed in the current pass.

## Operation
- FSM states:
  - IDLE → PULSE: on `start` = 1. Latch `pattern` and `len`, set the bit index to `len`−1, and clear `bits_sent`.
  - PULSE: `next` = 1 and `data` = pattern[idx] for `PULSE_CYCLES` cycles; then → GAP.
  - GAP: `next` = 0 and `data` = 0 for `GAP_CYCLES` cycles. On the last gap cycle:
    - → DONE if idx = 0 or `stop` has been seen;
    - otherwise decrement idx and → PULSE.
  - DONE: `done` = 1 for one cycle; then → IDLE.
- Bits are sent MSB-first from pattern[len−1] down to pattern[0].
- `bits_sent` increments on the last cycle of each PULSE and saturates at `len`.
- `len` = 0: go IDLE → DONE directly, with no strobes.
- `len` > `WIDTH`: clamp to `WIDTH`.
- `start` while `busy` = 1 or in DONE: ignored, with no queuing. The caller must reassert `start`.
- `stop`: sticky once asserted while busy, cleared on entry to IDLE. The current pulse and gap always complete. The detector never sees a truncated strobe.
- Changes to `pattern` or `len` after acceptance have no effect on the transfer in progress.
- Reset mid-transfer: all outputs go to 0 and the FSM to IDLE immediately, even if a strobe is cut short.

## Timing
- Reset values: `next` = 0, `data` = 0, `busy` = 0, `done` = 0, `bits_sent` = 0.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- With `start` sampled at edge t:
  - `busy` = 1 and `next` = 1 from cycle t+1.
  - Each bit occupies P = `PULSE_CYCLES` + `GAP_CYCLES` cycles.
  - `done` is high in cycle t+1+len·P, with `busy` = 0 in that same cycle.
  - The earliest next accepted `start` is sampled in cycle t+2+len·P.
- `data` is valid for the entire time `next` is high, and changes only at PULSE entry and exit.

## Configuration
- `SEQ_GEN_REPEAT_EN` defined:
  - After the last bit's gap (with no stop pending), reload idx = `len`−1, clear `bits_sent`, and go directly to PULSE.
  - `busy` stays 1 across the wrap.
  - `done` pulses for one cycle concurrently with the first PULSE cycle of each new pass.
  - The transfer exits to DONE/IDLE only via `stop` (or `len` = 0).
- `SEQ_GEN_REPEAT_EN` not defined: one pass per `start`, and `stop` only shortens a pass. No repeat logic is synthesized.

## Test plan
- Basic pass:
  - Stimulus: defaults, reset, `start` with `pattern` = 12'h2D2, `len` = 11.
  - Required `data` during the 11 strobes, each 2 cycles high and 27 cycles apart: 0,1,0,1,1,0,1,0,0,1,0.
  - Required at end: `done` exactly 297 cycles after the first strobe; `bits_sent` = 11.
- Edge lengths:
  - `len` = 0 → `done` one cycle after acceptance, with no `next` strobe.
  - `len` = 15 → behaves as `len` = 12, sending pattern[11:0].
- Busy protection:
  - Stimulus: `start` with a new pattern at strobe 3, and again in the `done` cycle.
  - Required: both ignored; the original sequence is unchanged; `busy` drops only at `done`.
- Stop:
  - Stimulus: `stop` pulsed mid-PULSE of bit 4 (`len` = 8).
  - Required: bit 4 completes its full pulse and gap; then `done`; `bits_sent` = 4; no 5th strobe.
- Async reset:
  - Stimulus: `reset` asserted on the second cycle of a strobe, between clock edges.
  - Required: `next`, `data`, `busy`, `bits_sent` go to 0 without waiting for a clock edge; a fresh `start` afterwards behaves as in the basic pass.
- Repeat (`SEQ_GEN_REPEAT_EN` defined):
  - Stimulus: `len` = 3, `pattern` = 3'b101.
  - Required: continuous 1,0,1,1,0,1…; `done` pulses every 81 cycles while `busy` stays 1; `stop` ends the transfer after the current bit.
